// File: rtl/viterbi_acs_ctrl_if.sv
// Handshake and control bundle between the BMU front end, the ACS sequencer,
// the survivor memory and the traceback engine.
interface viterbi_acs_ctrl_if #(
    parameter int PM_WIDTH = 13,
    parameter int TB_DEPTH = 64
);
    localparam int ADDR_W = $clog2(2 * TB_DEPTH);

    logic                start;
    logic                sym_valid;
    logic                last;
    logic                sym_ready;
    logic [PM_WIDTH-1:0] min_pm;
    logic                acs_en;
    logic                pm_init;
    logic                norm_en;
    logic                surv_wr_en;
    logic [ADDR_W-1:0]   surv_wr_addr;
    logic                tb_start;
    logic [ADDR_W-1:0]   tb_start_addr;
    logic [ADDR_W:0]     tb_len;
    logic                tb_flush;
    logic                tb_done;
    logic                busy;
    logic                frame_done;

    modport slave (
        input  start, sym_valid, last, min_pm, tb_done,
        output sym_ready, acs_en, pm_init, norm_en, surv_wr_en, surv_wr_addr,
               tb_start, tb_start_addr, tb_len, tb_flush, busy, frame_done
    );

    modport master (
        output start, sym_valid, last, min_pm, tb_done,
        input  sym_ready, acs_en, pm_init, norm_en, surv_wr_en, surv_wr_addr,
               tb_start, tb_start_addr, tb_len, tb_flush, busy, frame_done
    );
endinterface

// File: rtl/viterbi_acs_ctrl.sv
// Sequencer for the 64-state ACS array: symbol intake, PM init/normalization,
// survivor ring writes and sliding-window / flush traceback scheduling.
module viterbi_acs_ctrl #(
    parameter int PM_WIDTH    = 13,
    parameter int TB_DEPTH    = 64,
    parameter int NORM_THRESH = 2 ** (PM_WIDTH - 2)
) (
    input logic               clk,
    input logic               rst,
    viterbi_acs_ctrl_if.slave bus
);
    localparam int ADDR_W = $clog2(2 * TB_DEPTH);
    localparam logic [ADDR_W:0]     RING_LEN = (ADDR_W + 1)'(2 * TB_DEPTH);
    localparam logic [ADDR_W:0]     WIN_LEN  = (ADDR_W + 1)'(TB_DEPTH);
    localparam logic [PM_WIDTH-1:0] NORM_LVL = PM_WIDTH'(NORM_THRESH);

    typedef enum logic [2:0] {
        IDLE, INIT, RUN, TB_ISSUE, TB_WAIT, FL_ISSUE, FL_WAIT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W:0]   pend;
    logic [ADDR_W:0]   pend_next;
    logic              accept;
    logic              pm_init;
    logic              surv_wr_en;
    logic [ADDR_W-1:0] surv_wr_addr;
    logic              tb_start;
    logic [ADDR_W-1:0] tb_start_addr;
    logic [ADDR_W:0]   tb_len;
    logic              tb_flush;
    logic              frame_done;

    assign accept    = (state == RUN) && bus.sym_valid;
    assign pend_next = pend + 1'b1;

    assign bus.sym_ready     = (state == RUN);
    assign bus.acs_en        = accept;
    assign bus.norm_en       = accept && (bus.min_pm >= NORM_LVL);
    assign bus.busy          = (state != IDLE);
    assign bus.pm_init       = pm_init;
    assign bus.surv_wr_en    = surv_wr_en;
    assign bus.surv_wr_addr  = surv_wr_addr;
    assign bus.tb_start      = tb_start;
    assign bus.tb_start_addr = tb_start_addr;
    assign bus.tb_len        = tb_len;
    assign bus.tb_flush      = tb_flush;
    assign bus.frame_done    = frame_done;

    // surv_wr_addr doubles as "last written address" when a traceback is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wp            <= '0;
            pend          <= '0;
            pm_init       <= 1'b0;
            surv_wr_en    <= 1'b0;
            surv_wr_addr  <= '0;
            tb_start      <= 1'b0;
            tb_start_addr <= '0;
            tb_len        <= '0;
            tb_flush      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            pm_init    <= 1'b0;
            surv_wr_en <= 1'b0;
            tb_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pm_init <= 1'b1;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    wp    <= '0;
                    pend  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        surv_wr_en   <= 1'b1;
                        surv_wr_addr <= wp;
                        wp           <= wp + 1'b1;
                        pend         <= pend_next;
                        // Frame end wins over a window trigger on the same symbol
                        if (bus.last)
                            state <= FL_ISSUE;
                        else if (pend_next == RING_LEN)
                            state <= TB_ISSUE;
                    end
                end
                TB_ISSUE: begin
                    tb_start      <= 1'b1;
                    tb_flush      <= 1'b0;
                    tb_start_addr <= surv_wr_addr;
                    tb_len        <= RING_LEN;
                    state         <= TB_WAIT;
                end
                TB_WAIT: begin
                    if (bus.tb_done && !tb_start) begin
                        pend  <= pend - WIN_LEN;
                        state <= RUN;
                    end
                end
                FL_ISSUE: begin
                    tb_start      <= 1'b1;
                    tb_flush      <= 1'b1;
                    tb_start_addr <= surv_wr_addr;
                    tb_len        <= pend;
                    state         <= FL_WAIT;
                end
                FL_WAIT: begin
                    if (bus.tb_done && !tb_start) begin
                        pend       <= '0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Scoreboard bench for viterbi_acs_ctrl: directed frames push expected writes,
// normalization flags and traceback requests; a monitor pops and compares.
module tb_viterbi_acs_ctrl;
    typedef struct {
        logic       flush;
        logic [6:0] addr;
        logic [7:0] len;
    } tb_req_t;

    logic clk;
    logic rst;
    viterbi_acs_ctrl_if #(.PM_WIDTH(13), .TB_DEPTH(64)) bus ();

    viterbi_acs_ctrl #(.PM_WIDTH(13), .TB_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks = 0;
    int         errors = 0;
    logic [6:0] exp_wr[$];
    logic       exp_norm[$];
    tb_req_t    exp_tb[$];
    int         pend_init = 0;
    int         pend_done = 0;
    logic [6:0] exp_wp;
    logic       auto_done;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_tb(input logic flush, input logic [6:0] addr, input logic [7:0] len);
        tb_req_t r;
        r.flush = flush;
        r.addr  = addr;
        r.len   = len;
        exp_tb.push_back(r);
    endtask

    task automatic start_frame();
        pend_init++;
        exp_wp    = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Holds the symbol until the controller accepts it; called at a negedge
    task automatic apply_stimulus(input logic is_last, input logic [12:0] pm, input logic norm);
        int   n = 0;
        logic ok;
        exp_wr.push_back(exp_wp);
        exp_norm.push_back(norm);
        exp_wp        = exp_wp + 1'b1;
        bus.sym_valid = 1'b1;
        bus.last      = is_last;
        bus.min_pm    = pm;
        do begin
            ok = bus.sym_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 2000);
        if (!ok) check_output("accept_timeout", 0, 1);
        bus.sym_valid = 1'b0;
        bus.last      = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output("busy_after_frame", int'(bus.busy), 0);
        @(negedge clk);
    endtask

    // Monitor: samples mid-low-phase so both inputs and state are settled
    initial begin
        tb_req_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.acs_en) begin
                    if (exp_norm.size() == 0) check_output("unexpected_accept", 1, 0);
                    else check_output("norm_en", int'(bus.norm_en), int'(exp_norm.pop_front()));
                end else if (bus.norm_en) begin
                    check_output("norm_without_acs", 1, 0);
                end
                if (bus.surv_wr_en) begin
                    if (exp_wr.size() == 0) check_output("unexpected_write", 1, 0);
                    else check_output("surv_wr_addr", int'(bus.surv_wr_addr), int'(exp_wr.pop_front()));
                end
                if (bus.tb_start) begin
                    if (exp_tb.size() == 0) begin
                        check_output("unexpected_tb_start", 1, 0);
                    end else begin
                        r = exp_tb.pop_front();
                        check_output("tb_flush", int'(bus.tb_flush), int'(r.flush));
                        check_output("tb_start_addr", int'(bus.tb_start_addr), int'(r.addr));
                        check_output("tb_len", int'(bus.tb_len), int'(r.len));
                    end
                end
                if (bus.pm_init) begin
                    check_output("pm_init_expected", int'(pend_init > 0), 1);
                    if (pend_init > 0) pend_init--;
                end
                if (bus.frame_done) begin
                    check_output("frame_done_expected", int'(pend_done > 0), 1);
                    if (pend_done > 0) pend_done--;
                end
            end
        end
    end

    // Traceback engine stand-in: answers each request a few cycles later
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.tb_start && auto_done && !rst) begin
                repeat (3) begin
                    @(negedge clk);
                    check_output("ready_during_tb", int'(bus.sym_ready), 0);
                end
                bus.tb_done = 1'b1;
                @(negedge clk);
                bus.tb_done = 1'b0;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        auto_done     = 1'b1;
        bus.start     = 1'b1;
        bus.sym_valid = 1'b1;
        bus.last      = 1'b0;
        bus.min_pm    = 13'd4000;
        bus.tb_done   = 1'b0;
        exp_wp        = '0;
        @(negedge clk);
        check_output("rst_sym_ready", int'(bus.sym_ready), 0);
        check_output("rst_acs_en", int'(bus.acs_en), 0);
        check_output("rst_norm_en", int'(bus.norm_en), 0);
        check_output("rst_busy", int'(bus.busy), 0);
        check_output("rst_pm_init", int'(bus.pm_init), 0);
        check_output("rst_surv_wr_en", int'(bus.surv_wr_en), 0);
        check_output("rst_tb_start", int'(bus.tb_start), 0);
        check_output("rst_tb_len", int'(bus.tb_len), 0);
        bus.start     = 1'b0;
        bus.sym_valid = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        $display("[TB] short frame with normalization vectors");
        start_frame();
        apply_stimulus(1'b0, 13'd2047, 1'b0);
        apply_stimulus(1'b0, 13'd2048, 1'b1);
        bus.min_pm = 13'd4000;
        #1;
        check_output("idle_norm_en", int'(bus.norm_en), 0);
        check_output("idle_acs_en", int'(bus.acs_en), 0);
        @(negedge clk);
        apply_stimulus(1'b0, 13'd4000, 1'b1);
        apply_stimulus(1'b0, 13'd0, 1'b0);
        push_tb(1'b1, 7'd4, 8'd5);
        pend_done++;
        apply_stimulus(1'b1, 13'd0, 1'b0);
        wait_idle();

        $display("[TB] long frame of 300 symbols");
        start_frame();
        push_tb(1'b0, 7'd127, 8'd128);
        push_tb(1'b0, 7'd63, 8'd128);
        push_tb(1'b0, 7'd127, 8'd128);
        push_tb(1'b1, 7'd43, 8'd108);
        pend_done++;
        for (int i = 1; i <= 300; i++) apply_stimulus(i == 300, 13'd100, 1'b0);
        wait_idle();

        $display("[TB] last on the 128th symbol");
        start_frame();
        push_tb(1'b1, 7'd127, 8'd128);
        pend_done++;
        for (int i = 1; i <= 128; i++) apply_stimulus(i == 128, 13'd0, 1'b0);
        wait_idle();

        $display("[TB] reset while waiting on a window traceback");
        auto_done = 1'b0;
        start_frame();
        push_tb(1'b0, 7'd127, 8'd128);
        for (int i = 1; i <= 128; i++) apply_stimulus(1'b0, 13'd0, 1'b0);
        repeat (4) @(negedge clk);
        check_output("tb_wait_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check_output("rst2_busy", int'(bus.busy), 0);
        check_output("rst2_tb_len", int'(bus.tb_len), 0);
        check_output("rst2_tb_start_addr", int'(bus.tb_start_addr), 0);
        check_output("rst2_surv_wr_addr", int'(bus.surv_wr_addr), 0);
        @(negedge clk);
        rst       = 1'b0;
        auto_done = 1'b1;
        @(negedge clk);
        start_frame();
        push_tb(1'b1, 7'd0, 8'd1);
        pend_done++;
        apply_stimulus(1'b1, 13'd0, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        check_output("left_writes", exp_wr.size(), 0);
        check_output("left_norm", exp_norm.size(), 0);
        check_output("left_tb", exp_tb.size(), 0);
        check_output("left_pm_init", pend_init, 0);
        check_output("left_frame_done", pend_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
